ky32_pipe_ctrl: RTL

KY32_PIPE_CTRL -- requirements
Module: KY32_pipe_ctrl

---
 rtl/ky32_pipe_ctrl_pkg.sv | 7 +
 rtl/ky32_pipe_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/ky32_pipe_ctrl_pkg.sv
// ky32_pipe_ctrl_pkg: shared KY32 pipeline-control types and defaults.
package ky32_pipe_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int MDIV_CYCLES_DEF = 32;
  localparam int CNT_W = 6;
  localparam int STALL_W = 16;
endpackage

// File: rtl/ky32_pipe_ctrl.sv
// ky32_pipe_ctrl: KY32 hazard/stall/flush control with multicycle mul/div sequencing.
module ky32_pipe_ctrl
  import ky32_pipe_ctrl_pkg::*;
#(
  parameter int MDIV_CYCLES = MDIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               id_mdiv,
  input  logic [4:0]         ex_rd,
  input  logic               ex_is_load,
  input  logic               br_taken,
  input  logic               mem_stall,
  output logic               pc_e,
  output logic               ifid_e,
  output logic               idex_e,
  output logic               exmem_e,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               md_start,
  output logic               md_abort,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic loaduse, stall_inc;
  logic pc_c, ifid_c, idex_c, exmem_c, flush_c, bubble_c, start_c, abort_c;
  assign loaduse = ex_is_load & (ex_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  always_comb begin
    pc_c = 1'b1;
    ifid_c = 1'b1;
    idex_c = 1'b1;
    exmem_c = 1'b1;
    flush_c = 1'b0;
    bubble_c = 1'b0;
    start_c = 1'b0;
    abort_c = 1'b0;
    stall_inc = 1'b0;
    state_nx = state;
    cnt_nx = cnt;
    if (mem_stall) begin
      pc_c = 1'b0;
      ifid_c = 1'b0;
      idex_c = 1'b0;
      exmem_c = 1'b0;
      stall_inc = 1'b1;
    end else if (br_taken) begin
      flush_c = 1'b1;
      bubble_c = 1'b1;
      abort_c = state != IDLE;
      state_nx = IDLE;
      cnt_nx = '0;
    end else if (state == BUSY) begin
      pc_c = 1'b0;
      ifid_c = 1'b0;
      bubble_c = 1'b1;
      stall_inc = 1'b1;
      state_nx = cnt == '0 ? DONE : BUSY;
      cnt_nx = cnt == '0 ? cnt : cnt - 1'b1;
    end else if (state == DONE) begin
      state_nx = IDLE;
    end else if (loaduse || id_mdiv) begin
      pc_c = 1'b0;
      ifid_c = 1'b0;
      bubble_c = 1'b1;
      stall_inc = 1'b1;
      start_c = !loaduse;
      state_nx = loaduse ? IDLE : BUSY;
      cnt_nx = loaduse ? cnt : CNT_W'(MDIV_CYCLES - 2);
    end
  end
  // Outputs are forced quiet for as long as the clear is held.
  assign pc_e = clrn & pc_c;
  assign ifid_e = clrn & ifid_c;
  assign idex_e = clrn & idex_c;
  assign exmem_e = clrn & exmem_c;
  assign ifid_flush = clrn & flush_c;
  assign idex_bubble = clrn & bubble_c;
  assign md_start = clrn & start_c;
  assign md_abort = clrn & abort_c;
  assign busy = clrn & (state != IDLE);
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
